// File: rtl/updn_ctr_sequencer.sv
// updn_ctr_sequencer: command-driven control front end for an up/down counter.
// Accepts one command at a time over valid/ready and turns it into a cycle-exact
// data/load/cen/up_dn sequence, watching the counter's terminal flag.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   cmd_valid_i   command present
//   cmd_ready_o   high only in idle; accept on cmd_valid_i && cmd_ready_o
//   cmd_op_i      00 LOAD, 01 RUN_UP, 10 RUN_DN, 11 RUN_TO_TERM
//   cmd_data_i    LOAD value / step count N / bit0 = direction (1 up)
//   ctr_tercnt_i  counter terminal flag
//   ctr_data_o    load value to counter
//   ctr_load_o    active-low synchronous load strobe
//   ctr_cen_o     counter enable (combinational in RUN_TO_TERM)
//   ctr_up_dn_o   1 = up, 0 = down
//   busy_o        high in any state other than idle
//   done_o        one-cycle pulse at command completion
//   wrap_cnt_o    saturating count of wraps in the last RUN_UP/RUN_DN
//   err_o         RUN_TO_TERM timed out; sticky until next accept
module updn_ctr_sequencer #(
  parameter int unsigned Width = 4,
  parameter int unsigned WrapW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [Width-1:0] cmd_data_i,
  input  logic             ctr_tercnt_i,
  output logic [Width-1:0] ctr_data_o,
  output logic             ctr_load_o,
  output logic             ctr_cen_o,
  output logic             ctr_up_dn_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WrapW-1:0] wrap_cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;
  typedef enum logic [1:0] {OpLoad, OpRunUp, OpRunDn, OpRunToTerm} op_e;

  // Guard limit is 2^Width: a full lap of the counter without seeing tercnt.
  localparam logic [Width:0]   GuardLimit = {1'b1, {Width{1'b0}}};
  localparam logic [Width-1:0] StepOne    = Width'(1);
  localparam logic [WrapW-1:0] WrapMax    = {WrapW{1'b1}};

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [Width-1:0] data_q, data_d;
  logic             up_dn_q, up_dn_d;
  logic [Width-1:0] step_q, step_d;
  logic [Width:0]   guard_q, guard_d;
  logic [WrapW-1:0] wrap_q, wrap_d;
  logic             err_q, err_d;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= OpLoad;
      data_q  <= '0;
      up_dn_q <= 1'b1;
      step_q  <= '0;
      guard_q <= '0;
      wrap_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      up_dn_q <= up_dn_d;
      step_q  <= step_d;
      guard_q <= guard_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    up_dn_d = up_dn_q;
    step_d  = step_q;
    guard_d = guard_q;
    wrap_d  = wrap_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          op_d   = op_e'(cmd_op_i);
          wrap_d = '0;
          err_d  = 1'b0;
          unique case (op_e'(cmd_op_i))
            OpLoad: begin
              data_d  = cmd_data_i;
              state_d = StLoad;
            end
            OpRunUp, OpRunDn: begin
              up_dn_d = (cmd_op_i == OpRunUp);
              step_d  = cmd_data_i;
              state_d = (cmd_data_i == '0) ? StDone : StRun;
            end
            OpRunToTerm: begin
              up_dn_d = cmd_data_i[0];
              guard_d = '0;
              state_d = StRun;
            end
            default: ;
          endcase
        end
      end
      StLoad: state_d = StDone;
      StRun: begin
        if (op_q == OpRunToTerm) begin
          guard_d = guard_q + 1'b1;
          if (ctr_tercnt_i) begin
            state_d = StDone;
          end else if (guard_d == GuardLimit) begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end else begin
          step_d = step_q - 1'b1;
          // cen is always high here, so tercnt means the counter wraps this edge
          if (ctr_tercnt_i && (wrap_q != WrapMax)) wrap_d = wrap_q + 1'b1;
          if (step_q == StepOne) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    ctr_load_o  = 1'b1;
    ctr_cen_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      StLoad: ctr_load_o = 1'b0;
      // Halting on tercnt within the same cycle keeps the counter from wrapping.
      StRun:  ctr_cen_o = (op_q == OpRunToTerm) ? !ctr_tercnt_i : 1'b1;
      StDone: done_o = 1'b1;
      default: ;
    endcase
  end

  assign ctr_data_o  = data_q;
  assign ctr_up_dn_o = up_dn_q;
  assign wrap_cnt_o  = wrap_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_updn_ctr_sequencer.sv
// Bench for updn_ctr_sequencer: a behavioural counter stands in for the real one,
// and a transaction-level model predicts every cycle of output per accepted command.
module tb_updn_ctr_sequencer;
  localparam int unsigned Width   = 4;
  localparam int unsigned WrapW   = 8;
  localparam int          Mod     = 1 << Width;
  localparam int          WrapMax = (1 << WrapW) - 1;

  logic             clk;
  logic             rst_n = 1'b1;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [Width-1:0] cmd_data;
  logic             ctr_tercnt;
  logic [Width-1:0] ctr_data;
  logic             ctr_load, ctr_cen, ctr_up_dn, busy, done, err;
  logic [WrapW-1:0] wrap_cnt;

  updn_ctr_sequencer #(.Width(Width), .WrapW(WrapW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_data_i  (cmd_data),
    .ctr_tercnt_i(ctr_tercnt),
    .ctr_data_o  (ctr_data),
    .ctr_load_o  (ctr_load),
    .ctr_cen_o   (ctr_cen),
    .ctr_up_dn_o (ctr_up_dn),
    .busy_o      (busy),
    .done_o      (done),
    .wrap_cnt_o  (wrap_cnt),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the up/down counter
  logic [Width-1:0] cnt = '0;
  logic             tie0 = 1'b0;
  always @(posedge clk) begin
    if (!ctr_load)    cnt <= ctr_data;
    else if (ctr_cen) cnt <= ctr_up_dn ? cnt + 1'b1 : cnt - 1'b1;
  end
  assign ctr_tercnt = tie0 ? 1'b0 : (ctr_up_dn ? (cnt == '1) : (cnt == '0));

  typedef struct packed {
    logic             ready, busy, done, load, cen, up;
    logic [Width-1:0] data;
    logic [WrapW-1:0] wrap;
    logic             err;
  } exp_t;

  exp_t             exp_q[$];
  int               exp_count = 0;
  logic             exp_up = 1'b1;
  logic [Width-1:0] exp_data = '0;
  int               exp_wrap = 0;
  logic             exp_err = 1'b0;
  bit               prev_idle = 1'b1;
  int               cen_cycles = 0;
  int               checks = 0;
  int               passes = 0;

  function automatic exp_t mk(bit busy_v, bit done_v, bit load_v, bit cen_v);
    exp_t e;
    e.ready = !busy_v;
    e.busy  = busy_v;
    e.done  = done_v;
    e.load  = load_v;
    e.cen   = cen_v;
    e.up    = exp_up;
    e.data  = exp_data;
    e.wrap  = exp_wrap[WrapW-1:0];
    e.err   = exp_err;
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
  endtask

  task automatic check_rec(input exp_t e);
    exp_t a;
    a.ready = cmd_ready;
    a.busy  = busy;
    a.done  = done;
    a.load  = ctr_load;
    a.cen   = ctr_cen;
    a.up    = ctr_up_dn;
    a.data  = ctr_data;
    a.wrap  = wrap_cnt;
    a.err   = err;
    checks++;
    if (a === e) passes++;
    else $display({"FAIL cycle t=%0t: got rdy=%b busy=%b done=%b load=%b cen=%b up=%b ",
                   "data=%0d wrap=%0d err=%b; want rdy=%b busy=%b done=%b load=%b cen=%b ",
                   "up=%b data=%0d wrap=%0d err=%b"}, $time,
                  a.ready, a.busy, a.done, a.load, a.cen, a.up, a.data, a.wrap, a.err,
                  e.ready, e.busy, e.done, e.load, e.cen, e.up, e.data, e.wrap, e.err);
  endtask

  // Per-cycle compare: expected busy cycles come from the queue, otherwise idle.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        prev_idle = 1'b0;
      end else begin
        e = mk(1'b0, 1'b0, 1'b1, 1'b0);
        prev_idle = 1'b1;
      end
      check_rec(e);
      if (ctr_cen) cen_cycles++;
    end else begin
      prev_idle = 1'b1;
    end
  end

  // Build the whole expected trace of a command from the counter value at accept.
  task automatic push_cmd(input int op, input int d);
    int c;
    c = exp_count;
    exp_wrap = 0;
    exp_err  = 1'b0;
    case (op)
      0: begin
        exp_data = d[Width-1:0];
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        c = d;
      end
      1, 2: begin
        exp_up = (op == 1);
        for (int i = 0; i < d; i++) begin
          exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1));
          if ((exp_up && c == Mod - 1) || (!exp_up && c == 0))
            if (exp_wrap < WrapMax) exp_wrap++;
          c = exp_up ? (c + 1) % Mod : (c + Mod - 1) % Mod;
        end
      end
      default: begin
        exp_up = d[0];
        if (tie0) begin
          for (int i = 0; i < Mod; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1));
          exp_err = 1'b1;
        end else begin
          int k;
          k = exp_up ? (Mod - 1 - c) : c;
          for (int i = 0; i < k; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1));
          exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
          c = exp_up ? Mod - 1 : 0;
        end
      end
    endcase
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0));
    exp_count = c;
  endtask

  task automatic do_cmd(input int op, input int d);
    bit acc;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_data  = d[Width-1:0];
    for (int n = 0; n < 64 && !acc; n++) begin
      @(posedge clk);
      if (prev_idle) acc = 1'b1;
    end
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_data  = Width'($urandom_range(0, Mod - 1));
    if (!acc) begin
      checks++;
      $display("FAIL accept: got no accept in 64 cycles, want accept (op=%0d)", op);
    end else begin
      cen_cycles = 0;
      push_cmd(op, d);
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 80 && !ok; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL drain: got %0d pending cycles, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int out_vec();
    return int'({cmd_ready, busy, done, ctr_load, ctr_cen, ctr_up_dn, ctr_data, wrap_cnt, err});
  endfunction

  localparam int ResetVec = int'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 8'd0, 1'b0});

  initial begin
    int op, d, pre;
    bit b2b, t0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = '0;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", out_vec(), ResetVec);
    idle_cycles(2);
    rst_n = 1'b1;

    // Reset three cycles into RUN_UP 10
    pre = exp_count;
    do_cmd(1, 10);
    idle_cycles(3);
    rst_n = 1'b0;
    exp_q.delete();
    exp_count = (pre + 3) % Mod;
    exp_up    = 1'b1;
    exp_data  = '0;
    exp_wrap  = 0;
    exp_err   = 1'b0;
    #1 chk("reset_mid_run", out_vec(), ResetVec);
    idle_cycles(1);
    rst_n = 1'b1;
    idle_cycles(2);
    chk("count_after_reset", int'(cnt), 3);

    do_cmd(0, 7);
    wait_drain();
    chk("load_count", int'(cnt), 7);
    chk("load_data", int'(ctr_data), 7);

    do_cmd(1, 15);
    wait_drain();
    chk("runup_count", int'(cnt), 6);
    chk("runup_wrap", int'(wrap_cnt), 1);
    chk("runup_dir", int'(ctr_up_dn), 1);
    chk("runup_cen", cen_cycles, 15);

    do_cmd(2, 15);
    wait_drain();
    chk("rundn_count", int'(cnt), 7);
    chk("rundn_wrap", int'(wrap_cnt), 1);
    chk("rundn_dir", int'(ctr_up_dn), 0);

    do_cmd(3, 1);
    wait_drain();
    chk("term_cen", cen_cycles, 8);
    chk("term_count", int'(cnt), 15);
    chk("term_tercnt", int'(ctr_tercnt), 1);
    chk("term_err", int'(err), 0);

    do_cmd(3, 1);
    wait_drain();
    chk("term_again_cen", cen_cycles, 0);

    tie0 = 1'b1;
    do_cmd(3, 1);
    wait_drain();
    tie0 = 1'b0;
    chk("timeout_cen", cen_cycles, 16);
    chk("timeout_err", int'(err), 1);

    do_cmd(0, 9);
    chk("err_clear_on_accept", int'(err), 0);
    wait_drain();

    for (int i = 0; i < 60; i++) begin
      op  = $urandom_range(0, 3);
      d   = $urandom_range(0, Mod - 1);
      b2b = ($urandom_range(0, 2) == 0);
      t0  = (op == 3) && ($urandom_range(0, 4) == 0);
      if (t0) begin
        wait_drain();
        tie0 = 1'b1;
      end
      do_cmd(op, d);
      if (t0 || !b2b) begin
        wait_drain();
        tie0 = 1'b0;
        chk("rand_count", int'(cnt), exp_count);
        idle_cycles($urandom_range(0, 2));
      end
    end
    wait_drain();
    chk("final_count", int'(cnt), exp_count);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1000000, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/updn_ctr_sequencer.md
# updn_ctr_sequencer

Command-driven control stage that sits directly upstream of the up/down counter and drives its `data`, `load`, `cen` and `up_dn` pins. It accepts one command at a time over a valid/ready handshake, turns it into a cycle-exact control sequence, and watches the counter's `tercnt` to stop at the terminal value and to count wrap events. It replaces hand-sequenced stimulus with one programmable front end.

## Interface
- `width`, 4, counter width; also the width of `cmd_data` and `ctr_data`
- `wrap_w`, 8, width of `wrap_cnt`
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  high only in IDLE; command accepted on edge with `cmd_valid && cmd_ready`
- `cmd_op`  in  2  00 LOAD, 01 RUN_UP, 10 RUN_DN, 11 RUN_TO_TERM
- `cmd_data`  in  width  LOAD: value; RUN_UP/RUN_DN: step count N; RUN_TO_TERM: bit0 = direction (1 up)
- `ctr_tercnt`  in  1  counter terminal flag (all ones counting up, all zeros counting down)
- `ctr_data`  out  width  load value to counter
- `ctr_load`  out  1  active-low synchronous load strobe to counter
- `ctr_cen`  out  1  counter enable
- `ctr_up_dn`  out  1  1 = up, 0 = down
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at command completion
- `wrap_cnt`  out  wrap_w  wraps seen in last RUN_UP/RUN_DN; saturating
- `err`  out  1  RUN_TO_TERM timed out; sticky until next accept

## Operation
- States: IDLE, LOAD, RUN, DONE. All registered except `ctr_cen`.
- IDLE: `cmd_ready`=1. On accept: latch op and data, clear `wrap_cnt` and `err`, load step counter with N (RUN_UP/DN) or guard counter with 0 (RUN_TO_TERM). LOAD -> LOAD; RUN_UP/DN with N=0 -> DONE; otherwise -> RUN.
- LOAD: `ctr_load`=0, `ctr_data`=latched value, `ctr_cen`=0, for exactly one cycle; -> DONE.
- RUN (RUN_UP/DN): `ctr_up_dn` = op direction; `ctr_cen`=1 every cycle; step counter decrements per cycle; on cycle where step counter = 1 -> DONE. Each RUN cycle with `ctr_cen`=1 and `ctr_tercnt`=1 increments `wrap_cnt` (saturates at 2^wrap_w-1).
- RUN (RUN_TO_TERM): `ctr_up_dn` = latched bit0; `ctr_cen` = !`ctr_tercnt` (combinational, so counter halts on the terminal value, never wraps). `ctr_tercnt`=1 -> DONE. Guard counter (width+1 bits) increments per cycle; reaching 2^width without `tercnt` -> set `err`, -> DONE.
- DONE: `done`=1, `ctr_cen`=0, `ctr_load`=1, `cmd_ready`=0; -> IDLE.
- `ctr_up_dn` and `ctr_data` hold last driven values outside LOAD/RUN.
- `cmd_valid` while `cmd_ready`=0 is ignored; the sender holds the command.

## Timing
- Reset (async, `reset`=0): state IDLE; `ctr_load`=1, `ctr_cen`=0, `ctr_up_dn`=1, `ctr_data`=0, `busy`=0, `done`=0, `wrap_cnt`=0, `err`=0, `cmd_ready`=1. Reset mid-command drops it; `ctr_cen` falls immediately.
- Accept at edge E0. LOAD: `ctr_load` low in cycle E0–E1, counter loads at E1, `done` in E1–E2, `cmd_ready` high from E2.
- RUN_UP/DN N>0: `ctr_cen` high for exactly N cycles (E0..EN), counter advances N times, `done` in EN–EN+1; ready from EN+1.
- N=0: `done` in E0–E1, no counter activity.
- RUN_TO_TERM already at terminal: `ctr_cen` never rises; `done` in E1–E2.
- Back-to-back: next command accepted no earlier than the edge after `done`.
- Step arithmetic unsigned, width bits; counter wraps modulo 2^width; sequencer does not track count value.

## Test plan
- Reset with `reset`=0 mid-RUN_UP N=10 after 3 cycles -> all outputs at reset values immediately, counter held 3 steps, next LOAD accepted normally.
- LOAD 4'b0111 -> `ctr_load` low exactly 1 cycle with `ctr_data`=7, count=7, `done` next cycle, `busy` high 2 cycles.
- From 7, RUN_UP N=15 -> `ctr_cen` high 15 cycles, final count=6, `wrap_cnt`=1, `ctr_up_dn`=1.
- From 6, RUN_DN N=15 -> final count=7, `wrap_cnt`=1, `ctr_up_dn`=0.
- From 7, RUN_TO_TERM up -> 8 enable cycles, count=15, `tercnt`=1, `err`=0; repeat immediately -> zero enable cycles, `done` one cycle after ready drops.
- RUN_TO_TERM with `ctr_tercnt` tied 0 -> `ctr_cen` high 16 cycles, `err`=1, `done` pulse; `err` cleared on next accept.
